// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//
// Byte buffer that sits directly behind uart_rx. Every word strobed in on
// rx_done_tick is stored in arrival order and presented first-word-fall-through
// on a valid/ready consumer port. This lets bursty serial reception coexist
// with a slow or stalling consumer. Any word that arrives while the buffer is
// full, with no pop in the same cycle, is dropped and recorded in a sticky
// overflow flag.
//
// Parameters
//   DBIT    data word width (matches uart_rx DBIT)
//   ADDR_W  address width; depth = 2**ADDR_W words
//
// Ports
//   clk           in   rising-edge system clock
//   reset         in   synchronous, active-high; overrides every other input
//   rx_done_tick  in   one-cycle strobe: rx_data is valid this cycle
//   rx_data       in   received word
//   m_data        out  head-of-queue word; meaningful only while m_valid=1
//   m_valid       out  FIFO non-empty
//   m_ready       in   consumer takes the head word when m_valid & m_ready
//   full          out  count == 2**ADDR_W
//   empty         out  count == 0
//   count         out  number of stored words, 0..2**ADDR_W
//   overflow      out  sticky: a word was dropped because the FIFO was full
//   overflow_clr  in   one-cycle pulse that clears overflow
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   rx_data,
    output logic [DBIT-1:0]   m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;

    logic pop;
    logic push;
    logic drop;

    // Flags are decoded from the registered count only, so m_valid never
    // depends combinationally on m_ready.
    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign m_valid = ~empty;
    assign count   = cnt;
    assign overflow = ovf;

    // Asynchronous read of the head slot; it only moves when rd_ptr or the
    // addressed slot is updated on a clock edge.
    assign m_data = mem[rd_ptr];

    assign pop  = m_valid & m_ready;
    // A full FIFO can still accept a word if the head leaves in the same
    // cycle: the freed slot is exactly the one wr_ptr points at.
    assign push = rx_done_tick & (~full | pop);
    assign drop = rx_done_tick & full & ~pop;

    // Storage: no reset on the array, contents survive reset and are simply
    // unreachable until rewritten. A tick coincident with reset is ignored.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers wrap naturally modulo depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (overflow_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         mcnt    = 0;
    logic       exp_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT presents a word that the consumer takes,
    // compare it against the oldest expected word.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("count_le_16", int'(count <= 5'd16), 1);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no word", m_data);
                end else begin
                    chk("m_data_order", int'(m_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // One clock cycle of stimulus. The reference model decides whether the
    // tick is stored, dropped or paired with a pop, then flags are checked.
    task automatic step(input logic t, input logic [7:0] d, input logic rdy, input logic clr);
        bit p, acc;
        p   = rdy && (mcnt > 0);
        acc = t && ((mcnt < 16) || p);
        if (acc) exp_q.push_back(d);
        if (t && !acc) exp_ovf = 1'b1;
        else if (clr)  exp_ovf = 1'b0;
        mcnt = mcnt + (acc ? 1 : 0) - (p ? 1 : 0);
        rx_done_tick = t;
        rx_data      = d;
        m_ready      = rdy;
        overflow_clr = clr;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        overflow_clr = 1'b0;
        m_ready      = 1'b0;
        chk("count", int'(count), mcnt);
        chk("full", int'(full), int'(mcnt == 16));
        chk("empty", int'(empty), int'(mcnt == 0));
        chk("overflow", int'(overflow), int'(exp_ovf));
    endtask

    task automatic do_reset(input logic t);
        reset        = 1'b1;
        rx_done_tick = t;
        rx_data      = 8'h77;
        m_ready      = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        exp_q.delete();
        mcnt    = 0;
        exp_ovf = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_full", int'(full), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;
        m_ready = 1'b0; overflow_clr = 1'b0;
        @(posedge clk); #1;
        do_reset(1'b0);

        // 1. reset with a coincident tick
        do_reset(1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);

        // 2. two words held, then one accepted
        step(1'b1, 8'h32, 1'b0, 1'b0);
        chk("t2_m_valid_after_first", int'(m_valid), 1);
        step(1'b1, 8'hED, 1'b0, 1'b0);
        chk("t2_count2", int'(count), 2);
        chk("t2_head32", int'(m_data), 8'h32);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_headED", int'(m_data), 8'hED);
        chk("t2_count1", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // no bypass: tick into an empty FIFO is not visible in the same cycle
        rx_done_tick = 1'b1; rx_data = 8'h9C;
        #2;
        chk("nobypass_m_valid", int'(m_valid), 0);
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // 3. fill to 16, then a dropped 17th word
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t3_full", int'(full), 1);
        chk("t3_count16", int'(count), 16);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("t3_overflow", int'(overflow), 1);

        // 5. clear, then clear coincident with another drop
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_cleared", int'(overflow), 0);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("t5_set_wins", int'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // 4. push and pop together while full
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("t4_count16", int'(count), 16);
        chk("t4_no_overflow", int'(overflow), 0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_drained", exp_q.size(), 0);

        // 6. random stream with wrap-around and a mid-stream reset
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                do_reset(1'b0);
                chk("t6_wr_ptr_restart", int'(dut.wr_ptr), 0);
                step(1'b1, 8'hC3, 1'b0, 1'b0);
                chk("t6_slot0_head", int'(m_data), 8'hC3);
            end
            step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
        end
        for (int i = 0; i < 40 && mcnt > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_empty", int'(empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
